// File: rtl/msg_block_packer.sv
// Packs a stream of 64-bit message words into 576-bit rate blocks for the sponge padder.
// Handles one message per reset and finishes with a last block that may be partial or empty.
module msg_block_packer (
    input  logic         clk,
    input  logic         reset,
    input  logic [63:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic [3:0]   s_bytes,
    output logic [575:0] in,
    output logic         in_ready,
    output logic         is_last,
    output logic [9:0]   byte_num,
    input  logic         buffer_full,
    output logic         done
);

    typedef enum logic [2:0] {
        FILL,
        SEND,
        SEND_FULL,
        SEND_LAST,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] blk_q [9];
    logic [63:0] blk_d [9];
    logic [3:0]  wcnt_q, wcnt_d;
    logic [6:0]  bcnt_q, bcnt_d;
    logic        s_ready_q, s_ready_d;
    logic        in_ready_q, in_ready_d;
    logic        is_last_q, is_last_d;
    logic [9:0]  byte_num_q, byte_num_d;
    logic        done_q, done_d;

    logic [3:0]  eff_bytes;
    logic [63:0] keep_mask;
    logic [6:0]  bcnt_sum;
    logic        xfer;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        blk_d   = blk_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;

        // A non-last word, or a malformed byte count, counts as a full word.
        eff_bytes = (s_last && (s_bytes != 4'd0) && (s_bytes <= 4'd8)) ? s_bytes : 4'd8;
        keep_mask = ~64'd0 << {(4'd8 - eff_bytes), 3'b000};
        bcnt_sum  = bcnt_q + {3'b000, eff_bytes};
        xfer      = in_ready_q & ~buffer_full;

        case (state_q)
            FILL: begin
                if (s_valid && s_ready_q) begin
                    for (int i = 0; i < 9; i++) begin
                        if (wcnt_q == i[3:0]) blk_d[i] = s_data & keep_mask;
                    end
                    wcnt_d = wcnt_q + 4'd1;
                    bcnt_d = bcnt_sum;
                    if (s_last) begin
                        state_d = (bcnt_sum < 7'd72) ? SEND_LAST : SEND_FULL;
                    end else if (wcnt_q == 4'd8) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    for (int i = 0; i < 9; i++) blk_d[i] = '0;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = FILL;
                end
            end
            SEND_FULL: begin
                // Message ended exactly on a block boundary: follow with an empty last block.
                if (xfer) begin
                    for (int i = 0; i < 9; i++) blk_d[i] = '0;
                    bcnt_d  = '0;
                    state_d = SEND_LAST;
                end
            end
            SEND_LAST: begin
                if (xfer) state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = FILL;
        endcase

        s_ready_d  = (state_d == FILL);
        in_ready_d = (state_d == SEND) || (state_d == SEND_FULL) || (state_d == SEND_LAST);
        is_last_d  = (state_d == SEND_LAST);
        byte_num_d = is_last_d ? {3'b000, bcnt_d} : 10'd0;
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FILL;
            // NOTE: the block buffer is reset too, so `in` reads 0 and no stale words survive a reset.
            for (int i = 0; i < 9; i++) blk_q[i] <= '0;
            wcnt_q     <= '0;
            bcnt_q     <= '0;
            s_ready_q  <= 1'b0;
            in_ready_q <= 1'b0;
            is_last_q  <= 1'b0;
            byte_num_q <= '0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            blk_q      <= blk_d;
            wcnt_q     <= wcnt_d;
            bcnt_q     <= bcnt_d;
            s_ready_q  <= s_ready_d;
            in_ready_q <= in_ready_d;
            is_last_q  <= is_last_d;
            byte_num_q <= byte_num_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        in = '0;
        for (int i = 0; i < 9; i++) in[575 - 64*i -: 64] = blk_q[i];
    end

    assign s_ready  = s_ready_q;
    assign in_ready = in_ready_q;
    assign is_last  = is_last_q;
    assign byte_num = byte_num_q;
    assign done     = done_q;

endmodule

// File: tb/tb_msg_block_packer.sv
// Self-checking bench for msg_block_packer: table of message lengths with random data and a
// byte-level reference model, plus hand sequences for back-pressure, gaps and mid-fill reset.
module tb_msg_block_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [3:0]   s_bytes;
    logic [575:0] in;
    logic         in_ready;
    logic         is_last;
    logic [9:0]   byte_num;
    logic         buffer_full;
    logic         done;

    msg_block_packer dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .s_bytes     (s_bytes),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [575:0] data;
        logic         last;
        logic [9:0]   bn;
    } blk_t;

    typedef struct {
        int len;
        bit gapped;
        bit rand_bp;
        int exp_blocks;
        int exp_last_bytes;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    bit          rand_bp = 1'b0;
    logic [63:0] msg_words [$];
    blk_t        got_q [$];
    blk_t        exp_q [$];
    blk_t        ref_q [$];

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Record each block on the cycle before the edge that transfers it.
    always @(negedge clk) begin
        if (in_ready && !buffer_full) got_q.push_back('{data: in, last: is_last, bn: byte_num});
        if (reset === 1'b1 && in_ready && !is_last) check("byte_num_nonlast", byte_num, 0);
        if (reset === 1'b1 && is_last) check("is_last_needs_ready", in_ready, 1);
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) buffer_full = 1'($urandom_range(0, 1));
    end

    task automatic build_words(input int len);
        msg_words.delete();
        for (int w = 0; w < (len + 7) / 8; w++) msg_words.push_back({$urandom, $urandom});
    endtask

    // Reference: flatten the message to bytes, then cut into 72-byte blocks plus a final remainder block.
    task automatic make_model(input int len);
        logic [7:0]   bq [$];
        logic [63:0]  w64;
        logic [575:0] d;
        int nw, nb, nfull;
        nw = (len + 7) / 8;
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            w64 = msg_words[w];
            nb  = (w == nw - 1) ? len - 8 * w : 8;
            for (int k = 0; k < nb; k++) bq.push_back(w64[63 - 8*k -: 8]);
        end
        nfull = bq.size() / 72;
        for (int b = 0; b <= nfull; b++) begin
            d = '0;
            for (int j = 0; j < 72; j++) begin
                if (b * 72 + j < bq.size()) d[575 - 8*j -: 8] = bq[b * 72 + j];
            end
            if (b < nfull) exp_q.push_back('{data: d, last: 1'b0, bn: 10'd0});
            else exp_q.push_back('{data: d, last: 1'b1, bn: 10'(bq.size() - 72 * nfull)});
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in", in, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_is_last", is_last, 0);
        check("rst_byte_num", byte_num, 0);
        check("rst_done", done, 0);
        check("rst_s_ready", s_ready, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("s_ready_after_reset", s_ready, 1);
    endtask

    task automatic put_word(input logic [63:0] d, input logic l, input logic [3:0] nb, input bit gapped);
        logic r;
        bit   acc;
        if (gapped) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        s_data = d;
        s_last = l;
        s_bytes = nb;
        s_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk);
            #1;
        end
        check("done", done, 1);
    endtask

    task automatic compare_blocks(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_blk%0d_in", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_blk%0d_is_last", tag, i), got_q[i].last, exp_q[i].last);
            check($sformatf("%s_blk%0d_byte_num", tag, i), got_q[i].bn, exp_q[i].bn);
        end
    endtask

    // Feeds msg_words as a message of len bytes after a fresh reset, then checks blocks and DONE behaviour.
    task automatic run_msg(input int len, input bit gapped, input bit rbp);
        int nw;
        nw = (len + 7) / 8;
        make_model(len);
        do_reset();
        got_q.delete();
        rand_bp = rbp;
        for (int w = 0; w < nw; w++) begin
            put_word(msg_words[w], w == nw - 1, (w == nw - 1) ? 4'(len - 8 * w) : 4'd8, gapped);
        end
        wait_done();
        rand_bp = 1'b0;
        buffer_full = 1'b0;
        compare_blocks($sformatf("len%0d", len));
        s_data = 64'hFFFF_FFFF_FFFF_FFFF;
        s_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("after_done_s_ready", s_ready, 0);
            check("after_done_in_ready", in_ready, 0);
            check("after_done_hold", done, 1);
        end
        s_valid = 1'b0;
    endtask

    vec_t vecs [9];
    logic [575:0] snap_in;

    initial begin
        reset = 1'b0;
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_bytes = 4'd8;
        buffer_full = 1'b0;

        vecs[0] = '{3,   0, 0, 1, 3};
        vecs[1] = '{80,  0, 0, 2, 8};
        vecs[2] = '{72,  0, 0, 2, 0};
        vecs[3] = '{150, 1, 1, 3, 6};
        vecs[4] = '{71,  0, 1, 1, 71};
        vecs[5] = '{144, 1, 0, 3, 0};
        vecs[6] = '{8,   0, 0, 1, 8};
        vecs[7] = '{1,   1, 1, 1, 1};
        vecs[8] = '{65,  0, 0, 1, 65};

        for (int v = 0; v < 9; v++) begin
            build_words(vecs[v].len);
            run_msg(vecs[v].len, vecs[v].gapped, vecs[v].rand_bp);
            check($sformatf("vec%0d_blocks", v), got_q.size(), vecs[v].exp_blocks);
            if (got_q.size() > 0)
                check($sformatf("vec%0d_last_bytes", v), got_q[got_q.size() - 1].bn, vecs[v].exp_last_bytes);
        end

        // Single short message with a fixed word.
        msg_words.delete();
        msg_words.push_back(64'h0123_4567_89AB_CDEF);
        run_msg(3, 0, 0);
        if (got_q.size() > 0) check("short_block", got_q[0].data, {24'h012345, 552'd0});
        else check("short_count", got_q.size(), 1);

        // Gap-free and gapped runs of the same 150-byte message must yield identical blocks.
        build_words(150);
        run_msg(150, 0, 0);
        ref_q = got_q;
        run_msg(150, 1, 1);
        check("gap_count", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            check($sformatf("gap_blk%0d", i), got_q[i].data, ref_q[i].data);

        // Back-pressure on the first block of an 80-byte message.
        build_words(80);
        make_model(80);
        do_reset();
        got_q.delete();
        buffer_full = 1'b1;
        for (int w = 0; w < 9; w++) put_word(msg_words[w], 1'b0, 4'd8, 1'b0);
        check("latency_in_ready", in_ready, 1);
        check("bp_block0", in, exp_q[0].data);
        snap_in = in;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_in_frozen", in, snap_in);
            check("bp_in_ready_held", in_ready, 1);
            check("bp_is_last_held", is_last, 0);
            check("bp_byte_num_held", byte_num, 0);
            check("bp_s_ready_low", s_ready, 0);
        end
        buffer_full = 1'b0;
        @(posedge clk);
        #1;
        check("bp_in_ready_fall", in_ready, 0);
        check("bp_s_ready_back", s_ready, 1);
        put_word(msg_words[9], 1'b1, 4'd8, 1'b0);
        wait_done();
        compare_blocks("bp");

        // Reset mid-fill, then a fresh 5-byte message must carry no stale words.
        build_words(40);
        do_reset();
        for (int w = 0; w < 4; w++) put_word(msg_words[w], 1'b0, 4'd8, 1'b0);
        build_words(5);
        run_msg(5, 0, 0);
        check("midrst_blocks", got_q.size(), 1);
        if (got_q.size() > 0) check("midrst_byte_num", got_q[0].bn, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
